// File: rtl/flow_ctrl_pkg.sv
// Shared rooth pipeline definitions: bus widths, flow command encodings and
// flow controller state encodings.
package flow_ctrl_pkg;

  localparam int unsigned ROOTH_CPU_WIDTH  = 32;
  localparam int unsigned ROOTH_FLOW_WIDTH = 2;

  localparam logic [1:0] FLOW_WORK    = 2'b00;
  localparam logic [1:0] FLOW_STOP    = 2'b01;
  localparam logic [1:0] FLOW_REFRESH = 2'b10;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fc_state_e;

endpackage

// File: rtl/flow_ctrl.sv
// Central pipeline flow controller: post-reset flush, JTAG halt handshake,
// hold/hazard stalls and jump redirection with deferral of held jumps.
module flow_ctrl
  import flow_ctrl_pkg::*;
#(
  parameter int unsigned CPU_WIDTH  = ROOTH_CPU_WIDTH,
  parameter int unsigned FLOW_WIDTH = ROOTH_FLOW_WIDTH,
  parameter int unsigned INIT_FLUSH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jtag_reset_flag_i,
  input  logic                  jtag_halt_req_i,
  output logic                  jtag_halted_o,
  input  logic                  jump_req_i,
  input  logic [CPU_WIDTH-1:0]  jump_addr_i,
  input  logic                  load_use_i,
  input  logic                  hold_req_i,
  output logic [FLOW_WIDTH-1:0] flow_pc_o,
  output logic                  next_pc_four_o,
  output logic [CPU_WIDTH-1:0]  next_pc_o,
  output logic [FLOW_WIDTH-1:0] flow_if_id_o,
  output logic [FLOW_WIDTH-1:0] flow_id_ex_o
);

  localparam int unsigned CNT_W = $clog2(INIT_FLUSH + 1);

  fc_state_e            state_q, state_d;
  logic [CNT_W-1:0]     init_cnt_q, init_cnt_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [CPU_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic                 halted_d;

  logic in_init, in_run, do_halt;

  assign in_init = (state_q == ST_INIT);
  assign in_run  = (state_q == ST_RUN);
  assign do_halt = (state_q == ST_HALT) || (in_run && jtag_halt_req_i);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= CNT_W'(INIT_FLUSH);
      pend_vld_q    <= 1'b0;
      pend_addr_q   <= '0;
      jtag_halted_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      pend_vld_q    <= pend_vld_d;
      pend_addr_q   <= pend_addr_d;
      jtag_halted_o <= halted_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    halted_d    = jtag_halted_o;
    if (jtag_reset_flag_i) begin
      state_d     = ST_INIT;
      init_cnt_d  = CNT_W'(INIT_FLUSH);
      pend_vld_d  = 1'b0;
      pend_addr_d = '0;
      halted_d    = 1'b0;
    end else if (in_init) begin
      init_cnt_d = init_cnt_q - CNT_W'(1);
      if (init_cnt_q <= CNT_W'(1)) state_d = ST_RUN;
    end else if (do_halt) begin
      state_d  = jtag_halt_req_i ? ST_HALT : ST_RUN;
      halted_d = jtag_halt_req_i;
      if (jump_req_i) begin
        pend_vld_d  = 1'b1;
        pend_addr_d = jump_addr_i;
      end
    end else if (!in_run) begin
      state_d = ST_INIT;
    end else if (hold_req_i) begin
      // Held jump is parked so the redirect happens once the hold clears
      if (jump_req_i) begin
        pend_vld_d  = 1'b1;
        pend_addr_d = jump_addr_i;
      end
    end else if (pend_vld_q || jump_req_i) begin
      pend_vld_d = 1'b0;
    end
  end

  // Zero-latency flow command decode
  always_comb begin
    flow_pc_o      = FLOW_WIDTH'(FLOW_WORK);
    flow_if_id_o   = FLOW_WIDTH'(FLOW_WORK);
    flow_id_ex_o   = FLOW_WIDTH'(FLOW_WORK);
    next_pc_four_o = 1'b1;
    next_pc_o      = '0;
    if (jtag_reset_flag_i || in_init || (!in_run && !do_halt)) begin
      flow_pc_o    = FLOW_WIDTH'(FLOW_REFRESH);
      flow_if_id_o = FLOW_WIDTH'(FLOW_REFRESH);
      flow_id_ex_o = FLOW_WIDTH'(FLOW_REFRESH);
    end else if (do_halt || hold_req_i) begin
      flow_pc_o    = FLOW_WIDTH'(FLOW_STOP);
      flow_if_id_o = FLOW_WIDTH'(FLOW_STOP);
      flow_id_ex_o = FLOW_WIDTH'(FLOW_STOP);
    end else if (pend_vld_q || jump_req_i) begin
      // A parked target is older than the live request, so it wins
      next_pc_four_o = 1'b0;
      next_pc_o      = pend_vld_q ? pend_addr_q : jump_addr_i;
      flow_if_id_o   = FLOW_WIDTH'(FLOW_REFRESH);
      flow_id_ex_o   = FLOW_WIDTH'(FLOW_REFRESH);
    end else if (load_use_i) begin
      flow_pc_o    = FLOW_WIDTH'(FLOW_STOP);
      flow_if_id_o = FLOW_WIDTH'(FLOW_STOP);
      flow_id_ex_o = FLOW_WIDTH'(FLOW_REFRESH);
    end
  end

endmodule

// File: tb/tb_flow_ctrl.sv
// Scoreboard bench for flow_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_flow_ctrl;

  typedef struct packed {
    logic [1:0]  pc;
    logic        four;
    logic [31:0] npc;
    logic [1:0]  ifid;
    logic [1:0]  idex;
    logic        halted;
  } exp_t;

  localparam logic [1:0] W = 2'b00, S = 2'b01, R = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jtag_reset_flag_i = 1'b0;
  logic        jtag_halt_req_i = 1'b0;
  logic        jtag_halted_o;
  logic        jump_req_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        load_use_i = 1'b0;
  logic        hold_req_i = 1'b0;
  logic [1:0]  flow_pc_o;
  logic        next_pc_four_o;
  logic [31:0] next_pc_o;
  logic [1:0]  flow_if_id_o;
  logic [1:0]  flow_id_ex_o;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  bit    stim_done = 1'b0;

  flow_ctrl #(.INIT_FLUSH(2)) dut (
    .clk(clk), .rst(rst),
    .jtag_reset_flag_i(jtag_reset_flag_i), .jtag_halt_req_i(jtag_halt_req_i),
    .jtag_halted_o(jtag_halted_o),
    .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
    .load_use_i(load_use_i), .hold_req_i(hold_req_i),
    .flow_pc_o(flow_pc_o), .next_pc_four_o(next_pc_four_o), .next_pc_o(next_pc_o),
    .flow_if_id_o(flow_if_id_o), .flow_id_ex_o(flow_id_ex_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [1:0] pc, logic four, logic [31:0] npc,
                              logic [1:0] ifid, logic [1:0] idex, logic h);
    exp_t e;
    e.pc = pc; e.four = four; e.npc = npc; e.ifid = ifid; e.idex = idex; e.halted = h;
    return e;
  endfunction

  function automatic exp_t e_all(logic [1:0] f, logic h);
    return mk(f, 1'b1, 32'h0, f, f, h);
  endfunction

  function automatic exp_t e_jmp(logic [31:0] a);
    return mk(W, 1'b0, a, R, R, 1'b0);
  endfunction

  // One cycle of stimulus: drive inputs after the edge, queue the expectation
  task automatic cyc(input logic r, input logic jrf, input logic jhq, input logic hr,
                     input logic lu, input logic jr, input logic [31:0] ja,
                     input exp_t e, input string nm);
    @(posedge clk);
    #1;
    rst = r; jtag_reset_flag_i = jrf; jtag_halt_req_i = jhq; hold_req_i = hr;
    load_use_i = lu; jump_req_i = jr; jump_addr_i = ja;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle at negedge
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = mk(flow_pc_o, next_pc_four_o, next_pc_o, flow_if_id_o, flow_id_ex_o, jtag_halted_o);
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got pc=%b four=%b npc=%h ifid=%b idex=%b halted=%b, expected pc=%b four=%b npc=%h ifid=%b idex=%b halted=%b",
                 nm, a.pc, a.four, a.npc, a.ifid, a.idex, a.halted,
                 e.pc, e.four, e.npc, e.ifid, e.idex, e.halted);
      end
    end
  end

  initial begin
    // Reset and INIT flush
    cyc(1, 0, 0, 0, 0, 0, 32'h0,   e_all(R, 0), "in_reset");
    cyc(0, 0, 0, 0, 0, 0, 32'h0,   e_all(R, 0), "init_1");
    cyc(0, 0, 0, 0, 0, 0, 32'h0,   e_all(R, 0), "init_2");
    cyc(0, 0, 0, 0, 0, 0, 32'h0,   e_all(W, 0), "run_idle");
    // Single-cycle jump
    cyc(0, 0, 0, 0, 0, 1, 32'h100, e_jmp(32'h100), "jump_100");
    cyc(0, 0, 0, 0, 0, 0, 32'h0,   e_all(W, 0), "after_jump");
    // Hold defers jump
    cyc(0, 0, 0, 1, 0, 1, 32'h200, e_all(S, 0), "hold_1");
    cyc(0, 0, 0, 1, 0, 1, 32'h200, e_all(S, 0), "hold_2");
    cyc(0, 0, 0, 1, 0, 1, 32'h200, e_all(S, 0), "hold_3");
    cyc(0, 0, 0, 0, 0, 0, 32'h0,   e_jmp(32'h200), "pend_apply_200");
    cyc(0, 0, 0, 0, 0, 0, 32'h0,   e_all(W, 0), "pend_cleared");
    // Parked target wins over a live jump
    cyc(0, 0, 0, 1, 0, 1, 32'h300, e_all(S, 0), "hold_park_300");
    cyc(0, 0, 0, 0, 0, 1, 32'h500, e_jmp(32'h300), "pend_beats_live");
    cyc(0, 0, 0, 0, 0, 0, 32'h0,   e_all(W, 0), "idle_after_pend");
    // Jump beats load-use; then load-use bubble
    cyc(0, 0, 0, 0, 1, 1, 32'h40,  e_jmp(32'h40), "jump_over_lu");
    cyc(0, 0, 0, 0, 1, 0, 32'h0,   mk(S, 1'b1, 32'h0, S, R, 1'b0), "load_use");
    cyc(0, 0, 0, 0, 0, 0, 32'h0,   e_all(W, 0), "idle_after_lu");
    // JTAG halt for 5 cycles
    cyc(0, 0, 1, 0, 0, 0, 32'h0,   e_all(S, 0), "halt_1");
    cyc(0, 0, 1, 0, 0, 0, 32'h0,   e_all(S, 1), "halt_2");
    cyc(0, 0, 1, 0, 0, 0, 32'h0,   e_all(S, 1), "halt_3");
    cyc(0, 0, 1, 0, 0, 0, 32'h0,   e_all(S, 1), "halt_4");
    cyc(0, 0, 1, 0, 0, 0, 32'h0,   e_all(S, 1), "halt_5");
    cyc(0, 0, 0, 0, 0, 0, 32'h0,   e_all(S, 1), "halt_release");
    cyc(0, 0, 0, 0, 0, 0, 32'h0,   e_all(W, 0), "resume");
    // JTAG reset during halt with a parked jump
    cyc(0, 0, 1, 0, 0, 0, 32'h0,   e_all(S, 0), "halt2_1");
    cyc(0, 0, 1, 0, 0, 1, 32'h300, e_all(S, 1), "halt2_park");
    cyc(0, 1, 1, 0, 0, 0, 32'h0,   e_all(R, 1), "jtag_reset");
    cyc(0, 0, 0, 0, 0, 1, 32'h700, e_all(R, 0), "jreset_init_1");
    cyc(0, 0, 0, 0, 0, 0, 32'h0,   e_all(R, 0), "jreset_init_2");
    cyc(0, 0, 0, 0, 0, 0, 32'h0,   e_all(W, 0), "jreset_run_no_jump");
    // Async reset mid-pend
    cyc(0, 0, 0, 1, 0, 1, 32'h400, e_all(S, 0), "hold_park_400");
    cyc(1, 0, 0, 0, 0, 0, 32'h0,   e_all(R, 0), "rst_mid_pend");
    cyc(0, 0, 0, 0, 0, 0, 32'h0,   e_all(R, 0), "rst_init_1");
    cyc(0, 0, 0, 0, 0, 0, 32'h0,   e_all(R, 0), "rst_init_2");
    cyc(0, 0, 0, 0, 0, 0, 32'h0,   e_all(W, 0), "rst_run_no_jump");
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!stim_done && budget < 1000) begin
      @(posedge clk);
      budget++;
    end
    repeat (2) @(posedge clk);
    n_checks++;
    if (!stim_done || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: stim_done=%0d pending=%0d, expected stim_done=1 pending=0",
               stim_done, exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flow_ctrl.md
Name: flow_ctrl

Overview:
Central pipeline flow controller for the rooth core.
- Consumer side: hazard, jump, long-latency hold and JTAG halt/reset requests.
- Producer side: FLOW_WORK / FLOW_STOP / FLOW_REFRESH commands for the PC register and the IF/ID and ID/EX pipeline registers, plus the next-PC selection (next_pc_four / next_pc) for the PC register.
- Owns the post-reset flush sequence, the JTAG halt handshake and deferral of jumps that arrive during a hold.

Parameters:
CPU_WIDTH, 32, address/data width.
FLOW_WIDTH, 2, width of flow command encoding.
INIT_FLUSH, 2, cycles of REFRESH issued after reset release or JTAG reset (min 1).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active high
jtag_reset_flag_i  input  1  JTAG core reset request (level)
jtag_halt_req_i  input  1  JTAG halt request (level)
jtag_halted_o  output  1  halt acknowledge, registered
jump_req_i  input  1  EX-stage taken branch/jump
jump_addr_i  input  CPU_WIDTH  jump target
load_use_i  input  1  ID-stage load-use hazard
hold_req_i  input  1  multicycle hold (divider busy / bus wait)
flow_pc_o  output  FLOW_WIDTH  command to PC register
next_pc_four_o  output  1  1 = PC+4, 0 = load next_pc_o
next_pc_o  output  CPU_WIDTH  jump target to PC register
flow_if_id_o  output  FLOW_WIDTH  command to IF/ID register
flow_id_ex_o  output  FLOW_WIDTH  command to ID/EX register

Behaviour:
- Encodings: FLOW_WORK=2'b00, FLOW_STOP=2'b01, FLOW_REFRESH=2'b10; 2'b11 is never driven.
- State register: INIT, RUN, HALT. Also init_cnt (clog2(INIT_FLUSH+1) bits), pend_vld, pend_addr, jtag_halted_o.
- Reset (async, rst=1) values:
  - state=INIT, init_cnt=INIT_FLUSH, pend_vld=0, pend_addr=0, jtag_halted_o=0.
  - Combinational outputs during rst: all flows REFRESH, next_pc_four_o=1, next_pc_o=0.
- Flow outputs are combinational from state and inputs (zero-latency). Jumps and stalls take effect in the same cycle as the request.
- Defaults: next_pc_four_o=1, next_pc_o=0 unless a jump is applied.
- Priority, highest first, evaluated every cycle:
  1. jtag_reset_flag_i: all flows REFRESH; next state INIT; init_cnt reloads INIT_FLUSH; pend_vld cleared; jtag_halted_o cleared.
  2. INIT: all flows REFRESH; init_cnt decrements; moves to RUN in the cycle after init_cnt reaches 1. INIT lasts exactly INIT_FLUSH cycles; all other requests are ignored.
  3. HALT, or RUN with jtag_halt_req_i:
     - All flows STOP; state=HALT; jtag_halted_o=1 from the next cycle.
     - When jtag_halt_req_i deasserts, go to RUN and clear jtag_halted_o; the same cycle drives STOP.
     - A jump_req_i seen while halting is latched into pend.
  4. RUN with hold_req_i: all flows STOP. If jump_req_i, latch pend_vld=1, pend_addr=jump_addr_i (re-latching the same target each cycle is allowed).
  5. RUN with pend_vld or jump_req_i:
     - flow_pc_o=WORK, next_pc_four_o=0.
     - next_pc_o = pend_addr if pend_vld, else jump_addr_i (pend wins).
     - flow_if_id_o=REFRESH, flow_id_ex_o=REFRESH; pend_vld cleared.
  6. RUN with load_use_i: flow_pc_o=STOP, flow_if_id_o=STOP, flow_id_ex_o=REFRESH (one bubble per asserted cycle).
  7. RUN idle: all WORK, next_pc_four_o=1.
- A jump outranks load_use in the same cycle: the load-use instruction is flushed.
- hold_req_i outranks a jump; the jump is deferred via pend and never lost.
- Asserting rst mid-halt or mid-pend discards everything, and INIT is re-entered on release.

Decomposition:
- Shared defines (rooth_defines): CPU_WIDTH, FLOW_WIDTH, FLOW_WORK/STOP/REFRESH, flow_ctrl state encodings (INIT=2'd0, RUN=2'd1, HALT=2'd2).
- No sub-module; optionally split the pending-jump latch into flow_pend_jump if reused by an interrupt controller later.

Test Plan:
- Reset release, INIT_FLUSH=2 -> 2 cycles all REFRESH, then all WORK, next_pc_four_o=1.
- RUN, jump_req_i=1, jump_addr_i=32'h0000_0100 for 1 cycle -> same cycle flow_pc_o=WORK, next_pc_four_o=0, next_pc_o=0x100, if_id/id_ex REFRESH; next cycle all WORK.
- hold_req_i=1 for 3 cycles with jump_req_i=1, addr 0x200 -> 3 cycles all STOP; cycle 4 jump applied with next_pc_o=0x200, pend_vld cleared.
- load_use_i=1 and jump_req_i=1 (addr 0x40) same cycle -> jump wins. Then load_use_i alone -> pc STOP, if_id STOP, id_ex REFRESH.
- jtag_halt_req_i=1 for 5 cycles -> all STOP; jtag_halted_o rises 1 cycle later; after deassert, halted_o falls next cycle and WORK resumes.
- jtag_reset_flag_i pulse during HALT with pend_vld=1 -> all REFRESH, halted_o=0, pend dropped, INIT_FLUSH cycles of REFRESH, then RUN with no jump applied.
